game_field_controller: RTL and testbench
========================================

GAME_FIELD_CONTROLLER -- requirements
Module: game_field_controller

Interface
REQ-001 The block SHALL have these parameters, one per line as name, default, meaning:
- N_OBS, 4, number of obstacle slots (1..8)
- OBS_W, 40, obstacle width in px
- OBS_H, 40, obstacle height in px
- PLAYER_W, 30, player width in px
- PLAYER_H, 30, player height in px
- PLAYER_Y, 315, player top edge in px
- SCREEN_W, 640, active width in px
- SCREEN_H, 480, active height in px
- SPEED_INIT, 8, initial fall step in px/tick
- SPEED_MAX, 16, fall step ceiling
- LEVEL_PTS, 10, points per speed increment
- SPAWN_TICKS, 30, ticks between spawn attempts
- LFSR_SEED, 16'hACE1, nonzero LFSR reset value

REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk, in, 1, system clock (CLOCK_50 domain)
- rst, in, 1, synchronous active-low reset
- game_en, in, 1, one-cycle game tick strobe
- start, in, 1, start/restart request, level
- player_x, in, 10, player left edge
- obs_x, out, 10*N_OBS, packed obstacle left edges (slot i at [10i+9:10i])
- obs_y, out, 10*N_OBS, packed obstacle top edges
- obs_active, out, N_OBS, slot occupied mask
- score, out, 16, obstacles cleared
- speed, out, 10, current fall step
- state, out, 2, 0=IDLE 1=PLAY 2=OVER
- game_over, out, 1, high while state==OVER

Function
REQ-003 FSM transitions SHALL be: IDLE->PLAY on a start rising edge; PLAY->OVER on collision; OVER->PLAY on a start rising edge; no other transitions.
- Start edge detection SHALL use start registered in clk; edges are acted on regardless of game_en.
REQ-004 Entering PLAY SHALL, in the same cycle, clear obs_active, zero score, load speed=SPEED_INIT and zero the spawn counter; obs_x/obs_y SHALL hold their values.
REQ-005 All position, spawn, score and collision updates SHALL occur only on cycles with game_en=1 and state==PLAY; every output SHALL hold in IDLE and OVER.
REQ-006 Collision SHALL be evaluated on a tick against the registered (pre-move) positions; slot i collides when active AND obs_x<player_x+PLAYER_W AND player_x<obs_x+OBS_W AND obs_y<PLAYER_Y+PLAYER_H AND PLAYER_Y<obs_y+OBS_H.
- Comparisons SHALL use 11-bit unsigned arithmetic so sums do not wrap.
REQ-007 On a colliding tick the FSM SHALL enter OVER at the next clock edge; movement, retire, spawn and score SHALL NOT update on that tick; game_over SHALL be high one cycle after the tick.
REQ-008 On a non-colliding tick, each active slot SHALL update as follows:
- If obs_y+speed >= SCREEN_H, the slot SHALL retire (active<=0) and score SHALL increment by 1, saturating at 16'hFFFF.
- Otherwise obs_y <= obs_y+speed.
REQ-009 Multiple retires on one tick SHALL add their count to score.
REQ-010 Speed SHALL increase by 1, capped at SPEED_MAX, on each tick where score crosses a multiple of LEVEL_PTS; the new speed applies from the next tick.
REQ-011 The spawn counter SHALL increment on each PLAY tick; on reaching SPAWN_TICKS-1 it SHALL wrap to 0 and trigger a spawn attempt.
REQ-012 A spawn SHALL fill the lowest-index slot that is inactive at tick start with obs_y=0 and obs_x=L, where L=lfsr[9:0] if lfsr[9:0]<=SCREEN_W-OBS_W, else lfsr[9:0]-512.
- If no slot is free, the spawn SHALL be dropped silently.
- A slot retiring on the same tick SHALL NOT be reused until the next tick.
REQ-013 The LFSR SHALL be 16-bit Fibonacci with taps 16,14,13,11 and SHALL advance every clk cycle, independent of state.

Reset
REQ-014 With rst=0 at a clk edge, the block SHALL set state=IDLE, obs_active=0, all obs_x=0, all obs_y=0, score=0, speed=SPEED_INIT, spawn counter=0, lfsr=LFSR_SEED and the start register=0; reset SHALL override all activity, including mid-PLAY.

Verification
REQ-015 The bench SHALL cover these directed scenarios:
- Reset, then start 0->1 -> state=1, score=0, speed=8, obs_active=0 the cycle after the edge.
- PLAY with player_x=600, 30 ticks -> slot 0 active, obs_y=0, obs_x<=600; 15 more ticks -> obs_y=120.
- Slot 0 at obs_y=472, speed 8, no collision, one tick -> obs_active[0]=0, score+1.
- Force score 9->10 on a tick -> speed=9 from the following tick; at speed 16, further levels -> stays 16.
- Obstacle at x=300,y=290 with player_x=310 on a tick -> game_over=1 next cycle, positions frozen; start edge -> PLAY with cleared mask.
- All N_OBS slots active at a spawn tick -> no slot changes, spawn dropped; rst=0 mid-PLAY -> all reset values next cycle.

Source files
------------

// File: rtl/game_field_controller.sv
// Falling-obstacle game field: start/play/over FSM, obstacle slots, scoring,
// speed levels and LFSR-driven spawn positions. One update step per game tick.

// Per-slot combinational logic: collision test and fall/retire step.
module game_field_slot #(
    parameter int OBS_W    = 40,
    parameter int OBS_H    = 40,
    parameter int PLAYER_W = 30,
    parameter int PLAYER_H = 30,
    parameter int PLAYER_Y = 315,
    parameter int SCREEN_H = 480
) (
    input  logic       active,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [9:0] player_x,
    input  logic [9:0] speed,
    output logic       hit,
    output logic       retire,
    output logic [9:0] y_nxt
);
    // 11-bit operands so edge sums never wrap
    logic [10:0] x11, y11, px11, y_sum;

    assign x11   = {1'b0, x};
    assign y11   = {1'b0, y};
    assign px11  = {1'b0, player_x};
    assign y_sum = y11 + {1'b0, speed};

    assign hit = active
               && (x11 < px11 + 11'(PLAYER_W))
               && (px11 < x11 + 11'(OBS_W))
               && (y11 < 11'(PLAYER_Y + PLAYER_H))
               && (11'(PLAYER_Y) < y11 + 11'(OBS_H));

    assign retire = active && (y_sum >= 11'(SCREEN_H));
    assign y_nxt  = y_sum[9:0];
endmodule

module game_field_controller #(
    parameter int          N_OBS       = 4,
    parameter int          OBS_W       = 40,
    parameter int          OBS_H       = 40,
    parameter int          PLAYER_W    = 30,
    parameter int          PLAYER_H    = 30,
    parameter int          PLAYER_Y    = 315,
    parameter int          SCREEN_W    = 640,
    parameter int          SCREEN_H    = 480,
    parameter int          SPEED_INIT  = 8,
    parameter int          SPEED_MAX   = 16,
    parameter int          LEVEL_PTS   = 10,
    parameter int          SPAWN_TICKS = 30,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 game_en,
    input  logic                 start,
    input  logic [9:0]           player_x,
    output logic [10*N_OBS-1:0]  obs_x,
    output logic [10*N_OBS-1:0]  obs_y,
    output logic [N_OBS-1:0]     obs_active,
    output logic [15:0]          score,
    output logic [9:0]           speed,
    output logic [1:0]           state,
    output logic                 game_over
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_OVER = 2'd2} state_t;

    state_t                    st;
    logic                      start_q;
    logic [15:0]               lfsr;
    logic [15:0]               spawn_cnt;
    logic [15:0]               lvl_cnt;      // score modulo LEVEL_PTS
    logic [N_OBS-1:0][9:0]     ox, oy;
    logic [N_OBS-1:0]          hit, retire;
    logic [N_OBS-1:0][9:0]     y_nxt;
    logic [N_OBS-1:0]          free_mask, spawn_oh;
    logic [3:0]                n_ret;
    logic [16:0]               score_sum;
    logic [15:0]               score_nxt, lvl_sum;
    logic                      start_rise, level_up, spawn_now;
    logic [9:0]                spawn_x;

    genvar g;
    generate
        for (g = 0; g < N_OBS; g++) begin : g_slot
            game_field_slot #(
                .OBS_W(OBS_W), .OBS_H(OBS_H), .PLAYER_W(PLAYER_W),
                .PLAYER_H(PLAYER_H), .PLAYER_Y(PLAYER_Y), .SCREEN_H(SCREEN_H)
            ) u_slot (
                .active(obs_active[g]), .x(ox[g]), .y(oy[g]),
                .player_x(player_x), .speed(speed),
                .hit(hit[g]), .retire(retire[g]), .y_nxt(y_nxt[g])
            );
        end
    endgenerate

    assign start_rise = start & ~start_q;
    assign free_mask  = ~obs_active;
    // isolate the lowest free slot (slots retiring this tick are still active here)
    assign spawn_oh   = free_mask & (~free_mask + N_OBS'(1));
    assign spawn_now  = (spawn_cnt == 16'(SPAWN_TICKS - 1));
    // fold out-of-range LFSR values back onto the screen
    assign spawn_x    = (11'(lfsr[9:0]) <= 11'(SCREEN_W - OBS_W)) ? lfsr[9:0]
                                                                  : lfsr[9:0] - 10'd512;

    // Count retirements and derive the saturated score and level crossing
    always_comb begin
        n_ret = '0;
        for (int i = 0; i < N_OBS; i++) n_ret = n_ret + {3'b0, retire[i]};
        score_sum = {1'b0, score} + 17'(n_ret);
        score_nxt = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        lvl_sum   = lvl_cnt + 16'(n_ret);
        level_up  = (lvl_sum >= 16'(LEVEL_PTS));
    end

    // Free-running spawn-position LFSR, taps 16,14,13,11
    always_ff @(posedge clk) begin
        if (!rst) lfsr <= LFSR_SEED;
        else      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    // Game FSM and all field state; updates only on non-colliding PLAY ticks
    always_ff @(posedge clk) begin
        if (!rst) begin
            st         <= S_IDLE;
            start_q    <= 1'b0;
            obs_active <= '0;
            ox         <= '0;
            oy         <= '0;
            score      <= '0;
            speed      <= 10'(SPEED_INIT);
            spawn_cnt  <= '0;
            lvl_cnt    <= '0;
        end else begin
            start_q <= start;
            case (st)
                S_IDLE, S_OVER: begin
                    if (start_rise) begin
                        st         <= S_PLAY;
                        obs_active <= '0;
                        score      <= '0;
                        speed      <= 10'(SPEED_INIT);
                        spawn_cnt  <= '0;
                        lvl_cnt    <= '0;
                    end
                end
                S_PLAY: begin
                    if (game_en) begin
                        if (|hit) begin
                            st <= S_OVER;
                        end else begin
                            for (int i = 0; i < N_OBS; i++) begin
                                if (retire[i])          obs_active[i] <= 1'b0;
                                else if (obs_active[i]) oy[i]         <= y_nxt[i];
                                if (spawn_now && spawn_oh[i]) begin
                                    obs_active[i] <= 1'b1;
                                    ox[i]         <= spawn_x;
                                    oy[i]         <= '0;
                                end
                            end
                            score   <= score_nxt;
                            lvl_cnt <= lvl_sum % 16'(LEVEL_PTS);
                            if (level_up && speed < 10'(SPEED_MAX)) speed <= speed + 10'd1;
                            spawn_cnt <= spawn_now ? 16'd0 : spawn_cnt + 16'd1;
                        end
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

    assign obs_x     = ox;
    assign obs_y     = oy;
    assign state     = st;
    assign game_over = (st == S_OVER);
endmodule

// File: tb/tb_game_field_controller.sv
// Bench for game_field_controller: a tick-level reference model predicts the
// field after every clock; expectations queue up as stimulus is applied and
// are popped once the DUT edge has happened. Two slots so the field can fill.
module tb_game_field_controller;
    localparam int N = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0, game_en = 1'b0, start = 1'b0;
    logic [9:0]        player_x = '0;
    logic [10*N-1:0]   obs_x, obs_y;
    logic [N-1:0]      obs_active;
    logic [15:0]       score;
    logic [9:0]        speed;
    logic [1:0]        state;
    logic              game_over;
    int                tests = 0, fails = 0;

    typedef struct packed {
        logic [1:0]          st;
        logic [N-1:0]        act;
        logic [N-1:0][9:0]   x;
        logic [N-1:0][9:0]   y;
        logic [15:0]         score;
        logic [9:0]          speed;
    } snap_t;

    snap_t       m, cur, prev;
    snap_t       exp_q[$];
    int          m_cnt;
    logic        m_startq;
    logic [15:0] m_lfsr;

    game_field_controller #(.N_OBS(N)) dut (
        .clk(clk), .rst(rst), .game_en(game_en), .start(start), .player_x(player_x),
        .obs_x(obs_x), .obs_y(obs_y), .obs_active(obs_active), .score(score),
        .speed(speed), .state(state), .game_over(game_over)
    );

    always #5 clk = ~clk;

    function automatic snap_t dut_snap();
        snap_t s;
        s.st = state; s.act = obs_active; s.x = obs_x; s.y = obs_y;
        s.score = score; s.speed = speed;
        return s;
    endfunction

    // Reference model: next field state from current inputs
    function automatic void model_edge();
        logic [15:0] lf;
        bit rise, hit;
        int free, nret, old, nsc, yy, px, sx;
        lf = m_lfsr;
        if (!rst) begin
            m = '0; m.speed = 10'd8; m_cnt = 0; m_lfsr = 16'hACE1; m_startq = 1'b0;
            return;
        end
        m_lfsr = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
        rise = start && !m_startq;
        m_startq = start;
        if (m.st != 2'd1) begin
            if (rise) begin m.st = 2'd1; m.act = '0; m.score = '0; m.speed = 10'd8; m_cnt = 0; end
            return;
        end
        if (!game_en) return;
        px = int'(player_x);
        hit = 0;
        for (int i = 0; i < N; i++)
            if (m.act[i] && int'(m.x[i]) < px + 30 && px < int'(m.x[i]) + 40 &&
                int'(m.y[i]) < 345 && 315 < int'(m.y[i]) + 40) hit = 1;
        if (hit) begin m.st = 2'd2; return; end
        free = -1;
        for (int i = 0; i < N; i++) if (!m.act[i] && free < 0) free = i;
        nret = 0;
        for (int i = 0; i < N; i++) if (m.act[i]) begin
            yy = int'(m.y[i]) + int'(m.speed);
            if (yy >= 480) begin m.act[i] = 1'b0; nret++; end
            else m.y[i] = 10'(yy);
        end
        old = int'(m.score);
        nsc = old + nret;
        if (nsc > 65535) nsc = 65535;
        m.score = 16'(nsc);
        if ((old / 10) != (nsc / 10) && m.speed < 10'd16) m.speed = m.speed + 10'd1;
        if (m_cnt == 29) begin
            m_cnt = 0;
            if (free >= 0) begin
                sx = int'(lf[9:0]);
                if (sx > 600) sx = sx - 512;
                m.act[free] = 1'b1; m.x[free] = 10'(sx); m.y[free] = '0;
            end
        end else m_cnt++;
    endfunction

    // One clock: predict, queue the expectation, clock the DUT, pop it
    task automatic cyc();
        model_edge();
        exp_q.push_back(m);
        @(posedge clk);
        @(negedge clk);
        cur = exp_q.pop_front();
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; game_en = 1'b1; player_x = 10'd100;
        cyc(); cyc();
        tests++; if (state !== 2'd0 || game_over !== 1'b0) begin fails++;
            $display("FAIL reset_state: got %0d/%b want 0/0", state, game_over); end
        tests++; if (obs_active !== '0 || obs_x !== '0 || obs_y !== '0) begin fails++;
            $display("FAIL reset_field: got act=%b x=%h y=%h want zeros", obs_active, obs_x, obs_y); end
        tests++; if (score !== 16'd0 || speed !== 10'd8) begin fails++;
            $display("FAIL reset_score: got score=%0d speed=%0d want 0/8", score, speed); end
    endtask

    task automatic test_start();
        rst = 1'b1; game_en = 1'b1;
        repeat (3) cyc();
        tests++; if (state !== 2'd0 || score !== 16'd0) begin fails++;
            $display("FAIL idle_hold: got state=%0d want 0", state); end
        start = 1'b1; game_en = 1'b0;
        cyc();
        tests++; if (state !== 2'd1 || score !== 16'd0 || speed !== 10'd8 || obs_active !== '0) begin fails++;
            $display("FAIL start_play: got st=%0d sc=%0d sp=%0d act=%b want 1/0/8/0", state, score, speed, obs_active); end
        tests++; if (dut_snap() !== cur) begin fails++;
            $display("FAIL start_model: got %h want %h", dut_snap(), cur); end
    endtask

    task automatic test_spawn();
        player_x = 10'd600; game_en = 1'b1;
        repeat (29) cyc();
        tests++; if (obs_active !== '0) begin fails++;
            $display("FAIL spawn_early: got act=%b want 0", obs_active); end
        cyc();
        tests++; if (obs_active !== N'(1) || obs_y[9:0] !== 10'd0 || obs_x[9:0] > 10'd600) begin fails++;
            $display("FAIL spawn_first: got act=%b x=%0d y=%0d want 01/<=600/0", obs_active, obs_x[9:0], obs_y[9:0]); end
        tests++; if (dut_snap() !== cur) begin fails++;
            $display("FAIL spawn_model: got %h want %h", dut_snap(), cur); end
        game_en = 1'b0;
        repeat (3) cyc();
        tests++; if (obs_y[9:0] !== 10'd0 || dut_snap() !== cur) begin fails++;
            $display("FAIL hold_no_tick: got %h want %h", dut_snap(), cur); end
        game_en = 1'b1;
        repeat (15) cyc();
        tests++; if (obs_y[9:0] !== 10'd120) begin fails++;
            $display("FAIL fall_120: got y=%0d want 120", obs_y[9:0]); end
    endtask

    task automatic test_retire();
        player_x = 10'd700;
        repeat (44) cyc();
        tests++; if (obs_y[9:0] !== 10'd472 || speed !== 10'd8 || score !== 16'd0) begin fails++;
            $display("FAIL pre_retire: got y=%0d sp=%0d sc=%0d want 472/8/0", obs_y[9:0], speed, score); end
        // slot 0 retires while both slots were busy at tick start: spawn dropped
        cyc();
        tests++; if (obs_active !== 2'b10 || score !== 16'd1) begin fails++;
            $display("FAIL retire_drop: got act=%b sc=%0d want 10/1", obs_active, score); end
        tests++; if (dut_snap() !== cur) begin fails++;
            $display("FAIL retire_model: got %h want %h", dut_snap(), cur); end
    endtask

    task automatic test_level();
        int n;
        bit bad;
        n = 0;
        while (m.score < 16'd9 && n < 3000) begin cyc(); n++; end
        tests++; if (score !== 16'd9 || speed !== 10'd8) begin fails++;
            $display("FAIL level_pre: got sc=%0d sp=%0d want 9/8", score, speed); end
        while (m.score < 16'd10 && n < 3000) begin cyc(); n++; end
        tests++; if (score !== 16'd10 || speed !== 10'd9) begin fails++;
            $display("FAIL level_up: got sc=%0d sp=%0d want 10/9", score, speed); end
        cyc();
        tests++; if (dut_snap() !== cur) begin fails++;
            $display("FAIL level_step9: got %h want %h", dut_snap(), cur); end
        bad = 0;
        n = 0;
        while (m.score < 16'd90 && n < 8000 && !bad) begin
            cyc(); n++;
            tests++; if (dut_snap() !== cur) begin fails++; bad = 1;
                $display("FAIL level_run: got %h want %h", dut_snap(), cur); end
        end
        tests++; if (speed !== 10'd16 || score < 16'd90) begin fails++;
            $display("FAIL speed_cap: got sp=%0d sc=%0d want 16/>=90", speed, score); end
    endtask

    task automatic test_collision();
        int n, k;
        n = 0; k = -1;
        while (k < 0 && n < 400) begin
            for (int i = 0; i < N; i++)
                if (m.act[i] && m.y[i] > 10'd275 && m.y[i] <= 10'd328) k = i;
            if (k < 0) begin cyc(); n++; end
        end
        tests++; if (k < 0) begin fails++;
            $display("FAIL coll_setup: got no obstacle in band want one within 400 ticks"); return; end
        // touching the right edge exactly is not a hit
        player_x = m.x[k] + 10'd40;
        cyc();
        tests++; if (state !== 2'd1 || dut_snap() !== cur) begin fails++;
            $display("FAIL coll_edge: got st=%0d want 1", state); end
        prev = m;
        player_x = m.x[k] + 10'd10;
        cyc();
        tests++; if (state !== 2'd2 || game_over !== 1'b1) begin fails++;
            $display("FAIL collide: got st=%0d go=%b want 2/1", state, game_over); end
        tests++; if (obs_y !== prev.y || obs_x !== prev.x || score !== prev.score || obs_active !== prev.act) begin fails++;
            $display("FAIL coll_frozen: got y=%h sc=%0d want y=%h sc=%0d", obs_y, score, prev.y, prev.score); end
        repeat (4) cyc();
        tests++; if (state !== 2'd2 || obs_y !== prev.y || dut_snap() !== cur) begin fails++;
            $display("FAIL over_hold: got %h want %h", dut_snap(), cur); end
        game_en = 1'b0; start = 1'b0;
        cyc();
        start = 1'b1;
        cyc();
        tests++; if (state !== 2'd1 || obs_active !== '0 || score !== 16'd0 || speed !== 10'd8) begin fails++;
            $display("FAIL restart: got st=%0d act=%b sc=%0d sp=%0d want 1/0/0/8", state, obs_active, score, speed); end
        tests++; if (obs_y !== prev.y || obs_x !== prev.x) begin fails++;
            $display("FAIL restart_hold: got y=%h want %h", obs_y, prev.y); end
    endtask

    task automatic test_reset_mid_play();
        game_en = 1'b1; player_x = 10'd700;
        repeat (40) cyc();
        tests++; if (dut_snap() !== cur) begin fails++;
            $display("FAIL midplay_model: got %h want %h", dut_snap(), cur); end
        rst = 1'b0;
        cyc();
        tests++; if (state !== 2'd0 || obs_active !== '0 || obs_x !== '0 || obs_y !== '0 ||
                     score !== 16'd0 || speed !== 10'd8 || game_over !== 1'b0) begin fails++;
            $display("FAIL reset_midplay: got %h want zeros/speed 8", dut_snap()); end
        rst = 1'b1; start = 1'b0;
        cyc();
        start = 1'b1;
        cyc();
        repeat (30) cyc();
        tests++; if (obs_active !== N'(1) || dut_snap() !== cur) begin fails++;
            $display("FAIL reseed_spawn: got %h want %h", dut_snap(), cur); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_spawn();
        test_retire();
        test_level();
        test_collision();
        test_reset_mid_play();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
